// File: rtl/lsu_mem_ctrl.sv
// Load/store unit front-end for a word-only, big-endian, registered-read data memory.
// Optional `LSU_PERF_CNT_EN adds load/store/error completion counters.
module lsu_mem_ctrl #(
    parameter int unsigned AddrW = 32,
    parameter int unsigned DataW = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             wr_i,
    input  logic [2:0]       funct3_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [DataW-1:0] wdata_i,
    output logic             ready_o,
    output logic             done_o,
    output logic             err_o,
    output logic [DataW-1:0] rdata_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [DataW-1:0] mem_data_w_o,
    output logic             mem_rw_o,
    input  logic [DataW-1:0] mem_data_r_i
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]      load_cnt_o,
    output logic [31:0]      store_cnt_o,
    output logic [31:0]      err_cnt_o
`endif
);

    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StRdw,
        StWr,
        StResp
    } state_e;

    state_e           state_q, state_d;
    logic             wr_q, wr_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [DataW-1:0] wdata_q, wdata_d;
    logic             err_q, err_d;
    logic [DataW-1:0] rdata_q, rdata_d;
    logic [AddrW-1:0] mem_addr_q, mem_addr_d;
    logic [DataW-1:0] mem_data_w_q, mem_data_w_d;

    logic             illegal_f3;
    logic             misaligned;
    logic             req_err;
    logic [DataW-1:0] load_ext;
    logic [DataW-1:0] store_merge;

    // Request decode, evaluated on the raw inputs during the accept cycle.
    always_comb begin
        illegal_f3 = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
        misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        req_err    = illegal_f3 || (wr_i && funct3_i[2]) || misaligned;
    end

    // The addressed byte/half always lands in the top of the word (big-endian).
    always_comb begin
        load_ext = mem_data_r_i;
        unique case (funct3_q)
            F3Byte:  load_ext = {{24{mem_data_r_i[31]}}, mem_data_r_i[31:24]};
            F3ByteU: load_ext = {24'h000000, mem_data_r_i[31:24]};
            F3Half:  load_ext = {{16{mem_data_r_i[31]}}, mem_data_r_i[31:16]};
            F3HalfU: load_ext = {16'h0000, mem_data_r_i[31:16]};
            default: load_ext = mem_data_r_i;
        endcase
    end

    always_comb begin
        if (funct3_q == F3Half) begin
            store_merge = {wdata_q[15:0], mem_data_r_i[15:0]};
        end else begin
            store_merge = {wdata_q[7:0], mem_data_r_i[23:0]};
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_data_w_d = mem_data_w_q;

        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    wr_d     = wr_i;
                    funct3_d = funct3_i;
                    wdata_d  = wdata_i;
                    err_d    = req_err;
                    if (req_err) begin
                        // Errors never touch the memory bus, so MemAddr keeps its old value.
                        state_d = StResp;
                    end else if (wr_i && (funct3_i == F3Word)) begin
                        state_d      = StWr;
                        mem_addr_d   = addr_i;
                        mem_data_w_d = wdata_i;
                    end else begin
                        state_d    = StRd;
                        mem_addr_d = addr_i;
                    end
                end
            end
            StRd: begin
                state_d = StRdw;
            end
            StRdw: begin
                if (wr_q) begin
                    mem_data_w_d = store_merge;
                    state_d      = StWr;
                end else begin
                    rdata_d = load_ext;
                    state_d = StResp;
                end
            end
            StWr: begin
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            wr_q         <= 1'b0;
            funct3_q     <= 3'b000;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_data_w_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_w_q <= mem_data_w_d;
        end
    end

    always_comb begin
        ready_o      = (state_q == StIdle);
        done_o       = (state_q == StResp);
        err_o        = (state_q == StResp) && err_q;
        mem_rw_o     = (state_q == StWr);
        rdata_o      = rdata_q;
        mem_addr_o   = mem_addr_q;
        mem_data_w_o = mem_data_w_q;
    end

`ifdef LSU_PERF_CNT_EN
    logic [31:0] load_cnt_q, load_cnt_d;
    logic [31:0] store_cnt_q, store_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;

    always_comb begin
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (state_q == StResp) begin
            if (err_q) begin
                err_cnt_d = err_cnt_q + 32'd1;
            end else if (wr_q) begin
                store_cnt_d = store_cnt_q + 32'd1;
            end else begin
                load_cnt_d = load_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        load_cnt_o  = load_cnt_q;
        store_cnt_o = store_cnt_q;
        err_cnt_o   = err_cnt_q;
    end
`endif

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- CPU-side initiator for the byte-addressed, big-endian data memory.
- That memory is word-only: 4 bytes at Addr..Addr+3, byte at Addr is bits [31:24], one MemRW line, registered read data.
- This block turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into memory cycles. It does sign/zero extension on loads and read-modify-write for sub-word stores.
- Sits between the single-cycle datapath (stall/handshake side) and the data memory.

Parameters:
ADDR_W, 32, width of CPU and memory address buses
DATA_W, 32, data word width (fixed at 32; parameter exists for port sizing only)

Ports:
Clk  input  1  clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Req  input  1  request strobe, sampled only while Ready=1
Wr  input  1  1=store, 0=load
Funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
Addr  input  ADDR_W  byte address
WData  input  32  store data, right-justified (byte in [7:0], half in [15:0])
Ready  output  1  block idle, may accept Req
Done  output  1  one-cycle completion pulse
Err  output  1  valid with Done; misaligned or illegal funct3
RData  output  32  extended load result, valid with Done, held until next load completes
MemAddr  output  ADDR_W  memory address
MemDataW  output  32  memory write data
MemRW  output  1  1=write, 0=read
MemDataR  input  32  memory read data, valid one edge after address presented with MemRW=0

Behaviour:
- Reset values (async, immediate on Rst_n=0):
  - state IDLE; Ready=1, Done=0, Err=0, MemRW=0.
  - RData=0, MemAddr=0, MemDataW=0.
  - A write in progress is abandoned; no MemRW pulse follows reset.
- States: IDLE, RD, RDW, WR, RESP.
- IDLE:
  - Ready=1. On edge E0 with Req=1, latch Wr/Funct3/Addr/WData.
  - Next state RESP with error if: Funct3 is 011/110/111; or Wr=1 and Funct3[2]=1; or H with Addr[0]=1; or W with Addr[1:0]!=0.
  - Otherwise: load -> RD; store W -> WR; store B/H -> RD.
- RD: MemAddr=latched Addr, MemRW=0. Memory registers data at next edge. Next state RDW.
- RDW: MemDataR valid; MemRW=0.
  - Load: at this edge RData is latched from MemDataR:
    - B sign-extends [31:24].
    - BU zero-extends [31:24].
    - H sign-extends [31:16].
    - HU zero-extends [31:16].
    - W takes all 32 bits.
    - Next state RESP.
  - Store B: merge buffer = {WData[7:0], MemDataR[23:0]}. Next state WR.
  - Store H: merge buffer = {WData[15:0], MemDataR[15:0]}. Next state WR.
- WR: MemRW=1 for exactly one cycle. MemAddr=latched Addr. MemDataW = WData (SW) or merge buffer (SB/SH). Next state RESP.
- RESP: Done=1, Err per decode, Ready=0, MemRW=0. Next state IDLE unconditionally.
- Latency, counted from the accept edge E0 to the Done cycle:
  - Load: Done in cycle after E2.
  - SW: Done in cycle after E1.
  - SB/SH: Done in cycle after E3.
  - Error: Done in cycle after E0.
- Req while Ready=0 is ignored (not queued). Back-to-back requests are accepted in the IDLE cycle following RESP.
- Err=1 completions never assert MemRW and leave RData unchanged.
- MemAddr holds its last value in IDLE and RESP. MemRW=0 in every state except WR.
- Bench clock period is 10 ns, so the memory's internal write delay settles within a cycle.

Optional Feature:
LSU_PERF_CNT_EN
- Defined: adds outputs LoadCnt[31:0], StoreCnt[31:0], ErrCnt[31:0]. Each is incremented in RESP according to the completion type; all wrap at 2^32 and reset to 0 asynchronously.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- SW Addr=0x20 WData=0x80FF7F01 -> one MemRW pulse, MemDataW=0x80FF7F01, Done cycle after E1, Err=0; then LW 0x20 -> RData=0x80FF7F01, Done cycle after E2.
- After the above: LB 0x20 -> 0xFFFFFF80; LBU 0x20 -> 0x00000080; LH 0x20 -> 0xFFFF80FF; HU 0x22 -> 0x00007F01; LB 0x23 -> 0x00000001.
- SB Addr=0x21 WData=0xAAAAAA55 -> read then single write of {0x55, bytes 0x22..0x24}; then LW 0x20 -> 0x80557F01.
- SH Addr=0x21 and LW Addr=0x22 -> Err=1 with Done in cycle after E0, no MemRW pulse, memory and RData unchanged; Funct3=011 -> Err=1.
- Rst_n=0 during RDW of an SB -> Ready=1 and MemRW=0 immediately, no write ever issued; LW 0x20 afterwards returns the pre-SB value.
- Req held high continuously for two LWs -> second accepted only in the IDLE cycle after the first Done. With LSU_PERF_CNT_EN: LoadCnt=2 after both, StoreCnt and ErrCnt unaffected.
